// File: rtl/swisv_pkg.sv
// Shared encodings for the SWIS-V multi-cycle core: opcodes, sequencer states, mux selects.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package swisv_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Sequencer state codes; also exported on the debug port.
    typedef enum logic [3:0] {
        ST_START      = 4'd0,
        ST_FETCH      = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXECUTE    = 4'd4,
        ST_MEM        = 4'd5,
        ST_MEM_WAIT   = 4'd6,
        ST_WRITEBACK  = 4'd7,
        ST_HALT       = 4'd8
    } state_t;

    // PC source mux
    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;  // branch / JAL target
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;  // datapath clears bit 0

    // Register-file write-back mux
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    function automatic logic opc_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: opc_legal = 1'b1;
            default:                                 opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state watchdog shared by the fetch and load wait states.
// Latency: expired is combinational on the cycle the count would reach MEM_TIMEOUT.
// Backpressure: none; counts only while count_en is high.
//
// Ports: clk, rst_n (async active-low), clear (restart at 0), count_en (one
// wait cycle without data), expired (this wait cycle is the MEM_TIMEOUT-th).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    // Flag the cycle whose increment lands on MEM_TIMEOUT so the FSM can leave
    // for HALT on the same edge; a data-valid in that cycle suppresses count_en.
    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/mem/writeback over one memory port.
// Latency: ALU/LUI/AUIPC 5, STORE 5, LOAD 6, BRANCH/JAL/JALR 4 cycles with zero-wait memory.
// Backpressure: o_mem_req held until i_mem_gnt; wait states bounded by MEM_TIMEOUT, then HALT.
//
// Ports: clk, i_rst_n; i_instr (IR), i_branch_taken, i_mem_gnt, i_mem_rvalid in;
// memory request/we/address-select, IR/PC/RF enables, PC and WB mux selects,
// o_instret pulse, sticky o_illegal / o_bus_err, o_state debug out.
module multicycle_sequencer
    import swisv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_branch_taken,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_sel_instr,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_sel,
    output logic        o_rf_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_instret,
    output logic        o_illegal,
    output logic        o_bus_err,
    output logic [3:0]  o_state
);

    state_t     state, next_state;
    logic       illegal_q, bus_err_q;
    logic       set_illegal, set_bus_err;
    logic       tmr_clear, tmr_count, tmr_expired;
    logic [6:0] opcode;
    logic       rd_nz;
    logic       unused_instr;

    assign opcode       = i_instr[6:0];
    assign rd_nz        = |i_instr[11:7];   // writes to x0 are suppressed here
    assign unused_instr = ^i_instr[31:12];

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (i_rst_n),
        .clear    (tmr_clear),
        .count_en (tmr_count),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_START;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        next_state      = state;
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_sel_instr = 1'b0;
        o_ir_we         = 1'b0;
        o_pc_we         = 1'b0;
        o_pc_sel        = PC_SEL_PLUS4;
        o_rf_we         = 1'b0;
        o_wb_sel        = WB_SEL_ALU;
        o_instret       = 1'b0;
        set_illegal     = 1'b0;
        set_bus_err     = 1'b0;
        tmr_clear       = 1'b0;
        tmr_count       = 1'b0;

        case (state)
            ST_START: next_state = ST_FETCH;

            ST_FETCH: begin
                o_mem_req       = 1'b1;
                o_mem_sel_instr = 1'b1;
                if (i_mem_gnt) begin
                    next_state = ST_FETCH_WAIT;
                    tmr_clear  = 1'b1;
                end
            end

            ST_FETCH_WAIT: begin
                o_mem_sel_instr = 1'b1;
                if (i_mem_rvalid) begin
                    o_ir_we    = 1'b1;
                    next_state = ST_DECODE;
                end else begin
                    tmr_count = 1'b1;
                    if (tmr_expired) begin
                        next_state  = ST_HALT;
                        set_bus_err = 1'b1;
                    end
                end
            end

            ST_DECODE: begin
                if (opc_legal(opcode)) begin
                    next_state = ST_EXECUTE;
                end else begin
                    next_state  = ST_HALT;
                    set_illegal = 1'b1;
                end
            end

            ST_EXECUTE: begin
                case (opcode)
                    OPC_BRANCH: begin
                        o_pc_we    = 1'b1;
                        o_pc_sel   = i_branch_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                        o_instret  = 1'b1;
                        next_state = ST_FETCH;
                    end
                    OPC_JAL, OPC_JALR: begin
                        o_pc_we    = 1'b1;
                        o_pc_sel   = (opcode == OPC_JAL) ? PC_SEL_BRANCH : PC_SEL_JALR;
                        o_rf_we    = rd_nz;
                        o_wb_sel   = WB_SEL_PC4;
                        o_instret  = 1'b1;
                        next_state = ST_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: next_state = ST_MEM;
                    default:             next_state = ST_WRITEBACK;
                endcase
            end

            ST_MEM: begin
                o_mem_req = 1'b1;
                o_mem_we  = (opcode == OPC_STORE);
                if (i_mem_gnt) begin
                    if (opcode == OPC_STORE) begin
                        o_pc_we    = 1'b1;
                        o_instret  = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_MEM_WAIT;
                        tmr_clear  = 1'b1;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (i_mem_rvalid) begin
                    o_rf_we    = rd_nz;
                    o_wb_sel   = WB_SEL_MEM;
                    o_pc_we    = 1'b1;
                    o_instret  = 1'b1;
                    next_state = ST_FETCH;
                end else begin
                    tmr_count = 1'b1;
                    if (tmr_expired) begin
                        next_state  = ST_HALT;
                        set_bus_err = 1'b1;
                    end
                end
            end

            ST_WRITEBACK: begin
                o_rf_we    = rd_nz;
                o_wb_sel   = WB_SEL_ALU;
                o_pc_we    = 1'b1;
                o_instret  = 1'b1;
                next_state = ST_FETCH;
            end

            ST_HALT: next_state = ST_HALT;

            default: next_state = ST_HALT;
        endcase
    end

    assign o_illegal = illegal_q;
    assign o_bus_err = bus_err_q;
    assign o_state   = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle expected output records.
// Latency: n/a.
// Backpressure: bench drives i_mem_gnt / i_mem_rvalid directly per cycle.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_instr = '0;
    logic        i_branch_taken = 1'b0;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic        o_mem_req, o_mem_we, o_mem_sel_instr, o_ir_we, o_pc_we;
    logic [1:0]  o_pc_sel, o_wb_sel;
    logic        o_rf_we, o_instret, o_illegal, o_bus_err;
    logic [3:0]  o_state;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .i_instr         (i_instr),
        .i_branch_taken  (i_branch_taken),
        .i_mem_gnt       (i_mem_gnt),
        .i_mem_rvalid    (i_mem_rvalid),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_sel_instr (o_mem_sel_instr),
        .o_ir_we         (o_ir_we),
        .o_pc_we         (o_pc_we),
        .o_pc_sel        (o_pc_sel),
        .o_rf_we         (o_rf_we),
        .o_wb_sel        (o_wb_sel),
        .o_instret       (o_instret),
        .o_illegal       (o_illegal),
        .o_bus_err       (o_bus_err),
        .o_state         (o_state)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       req, we, seli, irwe, pcwe;
        logic [1:0] pcsel;
        logic       rfwe;
        logic [1:0] wbsel;
        logic       instret, illegal, buserr;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        taken;
        int          n;
        outs_t [0:5] exp;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    outs_t exp_q[$];
    vec_t  vecs[$];

    function automatic outs_t mk(input int st, input int req, input int we, input int seli,
                                 input int irwe, input int pcwe, input int pcsel, input int rfwe,
                                 input int wbsel, input int instret, input int ill, input int be);
        outs_t o;
        o.state = 4'(st);   o.req = 1'(req);     o.we = 1'(we);       o.seli = 1'(seli);
        o.irwe = 1'(irwe);  o.pcwe = 1'(pcwe);   o.pcsel = 2'(pcsel); o.rfwe = 1'(rfwe);
        o.wbsel = 2'(wbsel); o.instret = 1'(instret); o.illegal = 1'(ill); o.buserr = 1'(be);
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.state = o_state;   o.req = o_mem_req;   o.we = o_mem_we;   o.seli = o_mem_sel_instr;
        o.irwe = o_ir_we;    o.pcwe = o_pc_we;    o.pcsel = o_pc_sel; o.rfwe = o_rf_we;
        o.wbsel = o_wb_sel;  o.instret = o_instret; o.illegal = o_illegal; o.buserr = o_bus_err;
        return o;
    endfunction

    function automatic vec_t mkv(input string nm, input logic [31:0] instr, input logic taken,
                                 input int n, input outs_t e0, input outs_t e1, input outs_t e2,
                                 input outs_t e3, input outs_t e4, input outs_t e5);
        vec_t v;
        v.name = nm; v.instr = instr; v.taken = taken; v.n = n;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
        return v;
    endfunction

    // Pop the oldest expectation and compare it against the live outputs.
    task automatic chk(input string nm);
        outs_t e, a;
        a = observe();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d req=%b we=%b si=%b ir=%b pc=%b ps=%0d rf=%b wb=%0d ret=%b ill=%b be=%b, want st=%0d req=%b we=%b si=%b ir=%b pc=%b ps=%0d rf=%b wb=%0d ret=%b ill=%b be=%b",
                         nm, a.state, a.req, a.we, a.seli, a.irwe, a.pcwe, a.pcsel, a.rfwe, a.wbsel,
                         a.instret, a.illegal, a.buserr, e.state, e.req, e.we, e.seli, e.irwe,
                         e.pcwe, e.pcsel, e.rfwe, e.wbsel, e.instret, e.illegal, e.buserr);
            end
        end
    endtask

    // One clock cycle: drive memory handshake on the falling edge, check 1ns later.
    task automatic cyc(input string nm, input logic g, input logic rv, input outs_t e);
        @(negedge clk);
        i_mem_gnt    = g;
        i_mem_rvalid = rv;
        exp_q.push_back(e);
        #1;
        chk(nm);
    endtask

    outs_t Z0, F, FWH, FW0, D, E, WB, WB0, MLD, MST, MW, MW0, MWI;
    outs_t EBT, EBN, EJ, EJ0, EJR, HI, HB;

    task automatic do_reset();
        @(negedge clk);
        i_rst_n = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        exp_q.push_back(Z0);
        #1 chk("reset_state");
        @(negedge clk);
        i_rst_n = 1'b1;
        exp_q.push_back(Z0);
        #1 chk("start_state");
    endtask

    initial begin
        Z0  = mk(0, 0,0,0,0,0,0,0,0,0, 0,0);
        F   = mk(1, 1,0,1,0,0,0,0,0,0, 0,0);
        FWH = mk(2, 0,0,1,1,0,0,0,0,0, 0,0);
        FW0 = mk(2, 0,0,1,0,0,0,0,0,0, 0,0);
        D   = mk(3, 0,0,0,0,0,0,0,0,0, 0,0);
        E   = mk(4, 0,0,0,0,0,0,0,0,0, 0,0);
        WB  = mk(7, 0,0,0,0,1,0,1,0,1, 0,0);
        WB0 = mk(7, 0,0,0,0,1,0,0,0,1, 0,0);
        MLD = mk(5, 1,0,0,0,0,0,0,0,0, 0,0);
        MST = mk(5, 1,1,0,0,1,0,0,0,1, 0,0);
        MW  = mk(6, 0,0,0,0,1,0,1,1,1, 0,0);
        MW0 = mk(6, 0,0,0,0,1,0,0,1,1, 0,0);
        MWI = mk(6, 0,0,0,0,0,0,0,0,0, 0,0);
        EBT = mk(4, 0,0,0,0,1,1,0,0,1, 0,0);
        EBN = mk(4, 0,0,0,0,1,0,0,0,1, 0,0);
        EJ  = mk(4, 0,0,0,0,1,1,1,2,1, 0,0);
        EJ0 = mk(4, 0,0,0,0,1,1,0,2,1, 0,0);
        EJR = mk(4, 0,0,0,0,1,2,1,2,1, 0,0);
        HI  = mk(8, 0,0,0,0,0,0,0,0,0, 1,0);
        HB  = mk(8, 0,0,0,0,0,0,0,0,0, 0,1);

        vecs.push_back(mkv("add_x6",   32'h00530333, 1'b0, 5, F, FWH, D, E,   WB,  Z0));
        vecs.push_back(mkv("lb_x7",    32'h00400383, 1'b0, 6, F, FWH, D, E,   MLD, MW));
        vecs.push_back(mkv("beq_t",    32'h02628063, 1'b1, 4, F, FWH, D, EBT, Z0,  Z0));
        vecs.push_back(mkv("beq_nt",   32'h02628063, 1'b0, 4, F, FWH, D, EBN, Z0,  Z0));
        vecs.push_back(mkv("jal_x7",   32'hFE5FF3EF, 1'b0, 4, F, FWH, D, EJ,  Z0,  Z0));
        vecs.push_back(mkv("jalr_x1",  32'h000380E7, 1'b0, 4, F, FWH, D, EJR, Z0,  Z0));
        vecs.push_back(mkv("sw",       32'h00602023, 1'b0, 5, F, FWH, D, E,   MST, Z0));
        vecs.push_back(mkv("lui_x0",   32'h00001037, 1'b0, 5, F, FWH, D, E,   WB0, Z0));
        vecs.push_back(mkv("addi_x1",  32'h00500093, 1'b0, 5, F, FWH, D, E,   WB,  Z0));
        vecs.push_back(mkv("auipc_x5", 32'h00000297, 1'b0, 5, F, FWH, D, E,   WB,  Z0));
        vecs.push_back(mkv("lw_x0",    32'h00002003, 1'b0, 6, F, FWH, D, E,   MLD, MW0));
        vecs.push_back(mkv("jal_x0",   32'h0000006F, 1'b0, 4, F, FWH, D, EJ0, Z0,  Z0));

        #12;
        do_reset();

        // Zero-wait memory: grant and rvalid held high; rvalid must be ignored
        // outside the wait states, including alongside a grant in FETCH/MEM.
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                @(negedge clk);
                i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1;
                if (k == 0) begin
                    i_instr        = vecs[i].instr;
                    i_branch_taken = vecs[i].taken;
                    for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].exp[j]);
                end
                #1 chk($sformatf("%s_c%0d", vecs[i].name, k));
            end
        end
        exp_q.delete();

        // Load with delayed grants in both FETCH and MEM.
        do_reset();
        i_instr = 32'h00400383;
        cyc("lbd_fetch_nogrant", 1'b0, 1'b1, F);
        cyc("lbd_fetch_grant",   1'b1, 1'b0, F);
        cyc("lbd_fw_wait",       1'b0, 1'b0, FW0);
        cyc("lbd_fw_hit",        1'b0, 1'b1, FWH);
        cyc("lbd_decode",        1'b0, 1'b1, D);
        cyc("lbd_exec",          1'b0, 1'b0, E);
        cyc("lbd_mem0",          1'b0, 1'b1, MLD);
        cyc("lbd_mem1",          1'b0, 1'b0, MLD);
        cyc("lbd_mem2",          1'b1, 1'b0, MLD);
        cyc("lbd_mw_wait",       1'b0, 1'b0, MWI);
        cyc("lbd_mw_hit",        1'b0, 1'b1, MW);
        cyc("lbd_next_fetch",    1'b0, 1'b0, F);

        // Illegal opcode halts, flag sticky, no further requests.
        do_reset();
        i_instr = 32'h0000000B;
        cyc("ill_fetch",  1'b1, 1'b0, F);
        cyc("ill_fw",     1'b0, 1'b1, FWH);
        cyc("ill_decode", 1'b0, 1'b0, D);
        for (int k = 0; k < 3; k++) cyc($sformatf("ill_halt%0d", k), 1'b1, 1'b1, HI);

        // Fetch wait-state timeout after 16 cycles without rvalid.
        do_reset();
        i_instr = 32'h00530333;
        cyc("to_fetch", 1'b1, 1'b0, F);
        for (int k = 1; k <= 16; k++) cyc($sformatf("to_fw%0d", k), 1'b0, 1'b0, FW0);
        cyc("to_halt0", 1'b1, 1'b1, HB);
        cyc("to_halt1", 1'b1, 1'b1, HB);

        // rvalid on the 16th wait cycle wins over the timeout.
        do_reset();
        cyc("late_fetch", 1'b1, 1'b0, F);
        for (int k = 1; k <= 15; k++) cyc($sformatf("late_fw%0d", k), 1'b0, 1'b0, FW0);
        cyc("late_fw16",  1'b0, 1'b1, FWH);
        cyc("late_dec",   1'b0, 1'b0, D);
        cyc("late_exec",  1'b0, 1'b0, E);
        cyc("late_wb",    1'b0, 1'b0, WB);

        // Load-data wait timeout.
        do_reset();
        i_instr = 32'h00400383;
        cyc("mto_fetch", 1'b1, 1'b0, F);
        cyc("mto_fw",    1'b0, 1'b1, FWH);
        cyc("mto_dec",   1'b0, 1'b0, D);
        cyc("mto_exec",  1'b0, 1'b0, E);
        cyc("mto_mem",   1'b1, 1'b0, MLD);
        for (int k = 1; k <= 16; k++) cyc($sformatf("mto_mw%0d", k), 1'b0, 1'b0, MWI);
        cyc("mto_halt",  1'b0, 1'b1, HB);

        // Reset asserted mid-MEM_WAIT while rvalid arrives.
        do_reset();
        cyc("rst_fetch", 1'b1, 1'b0, F);
        cyc("rst_fw",    1'b0, 1'b1, FWH);
        cyc("rst_dec",   1'b0, 1'b0, D);
        cyc("rst_exec",  1'b0, 1'b0, E);
        cyc("rst_mem",   1'b1, 1'b0, MLD);
        cyc("rst_mw",    1'b0, 1'b0, MWI);
        @(negedge clk);
        i_rst_n = 1'b0; i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1;
        exp_q.push_back(Z0);
        #1 chk("rst_mid_mw");
        @(negedge clk);
        exp_q.push_back(Z0);
        #1 chk("rst_held");
        i_rst_n = 1'b1;
        exp_q.push_back(Z0);
        #1 chk("rst_released_start");
        cyc("rst_post_fetch", 1'b0, 1'b1, F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
